uart_rx_sampler: RTL

//  Bit-level 8N1 UART receiver core. Recovers bytes from the serial line using 3-sample majority voting at mid-bit.

---
 rtl/uart_rx_sampler_pkg.sv | 15 +
 rtl/uart_rx_bit_timer.sv | 43 ++++
 rtl/uart_rx_sampler.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_pkg.sv
// Shared definitions for the uart_rx_sampler receiver: FSM state encoding and baud divider floor.
package uart_rx_sampler_pkg;

    localparam int MIN_BAUD_DIV = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer for uart_rx_sampler: latches baud_div while idle, counts clocks within a bit
// and raises the two mid-bit sample strobes and the decision strobe.
module uart_rx_bit_timer
    import uart_rx_sampler_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        latch,
    input  logic        clear,
    output logic        sample,
    output logic        decide
);

    logic [15:0] div_q;
    logic [15:0] cnt;
    logic [15:0] half;

    assign half = div_q >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 16'(MIN_BAUD_DIV);
            cnt   <= '0;
        end else begin
            // values below the floor are undefined; clamping keeps the strobes well-formed
            if (latch) begin
                div_q <= (baud_div < 16'(MIN_BAUD_DIV)) ? 16'(MIN_BAUD_DIV) : baud_div;
            end
            if (clear) begin
                cnt <= '0;
            end else if (cnt == div_q - 16'd1) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    assign sample = (cnt == half - 16'd1) || (cnt == half);
    assign decide = (cnt == half + 16'd1);

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver core with 3-sample mid-bit majority vote and rx_done/rx_read handshake.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a start edge; baud_div tracked
// START  | validating start bit at mid-bit (high vote = glitch)
// DATA   | collecting DATA_BITS votes, LSB first
// PARITY | checking even parity (UART_RX_PARITY_EN only)
// STOP   | stop vote: high delivers, low flags frame error
// BREAK  | line stuck low after a bad stop, waiting for high
module uart_rx_sampler
    import uart_rx_sampler_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] baud_div,
    input  logic        rx_pin,
    input  logic        rx_read,
    output logic        rx_done,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        overrun
);

    rx_state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync;
    logic                   line;
    logic [1:0]             samp;
    logic                   maj;
    logic                   sample;
    logic                   decide;
    logic [2:0]             bit_idx;
    logic [7:0]             shreg;
    logic                   par_err;
    logic                   shift_en;
    logic                   deliver;
    logic                   fe_now;
    logic                   ack;
    logic                   ack_wait;
    logic                   pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_pin};
        end
    end

    assign line = sync[SYNC_STAGES-1];
    assign maj  = (samp[1] & samp[0]) | (samp[1] & line) | (samp[0] & line);
    assign ack  = rx_done & rx_read & ~ack_wait;

    uart_rx_bit_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_div (baud_div),
        .latch    (state == ST_IDLE),
        .clear    (state_next == ST_IDLE),
        .sample   (sample),
        .decide   (decide)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        fe_now     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!line) state_next = ST_START;
            end
            ST_START: begin
                if (decide) state_next = maj ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = ST_PARITY;
`else
                        state_next = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (decide) begin
                    state_next = ST_STOP;
                    fe_now     = (maj != ^shreg);
                end
            end
            ST_STOP: begin
                // a parity error already raised frame_err for this frame
                if (decide) begin
                    if (maj) begin
                        state_next = ST_IDLE;
                        deliver    = ~par_err;
                    end else begin
                        state_next = ST_BREAK;
                        fe_now     = ~par_err;
                    end
                end
            end
            ST_BREAK: begin
                if (line) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (state == ST_START) begin
            par_err <= 1'b0;
        end else if (state == ST_PARITY && fe_now) begin
            par_err <= 1'b1;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp      <= '1;
            bit_idx   <= '0;
            shreg     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rx_done   <= 1'b0;
            rx_byte   <= '0;
            ack_wait  <= 1'b0;
            pend      <= 1'b0;
        end else begin
            frame_err <= fe_now;
            overrun   <= 1'b0;
            if (sample) samp <= {samp[0], line};
            if (state == ST_START) begin
                bit_idx <= '0;
                shreg   <= '0;
            end else if (shift_en) begin
                shreg[bit_idx] <= maj;
                bit_idx        <= bit_idx + 3'd1;
            end

            // ack_wait blocks a fresh rx_done until the consumer has released rx_read
            ack_wait <= ack | (ack_wait & rx_read);
            if (deliver) begin
                if (ack || (!rx_done && !pend)) begin
                    rx_byte <= shreg;
                    if (!rx_done && ack_wait && rx_read) begin
                        pend <= 1'b1;
                    end else begin
                        rx_done <= 1'b1;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end else if (ack) begin
                rx_done <= 1'b0;
            end else if (pend && !rx_read) begin
                rx_done <= 1'b1;
                pend    <= 1'b0;
            end
        end
    end

endmodule
